// File: rtl/mat_pkg.sv
// Shared definitions for the packed matrix bus used by the matrix blocks.
package mat_pkg;

  localparam int MAT_N  = 4;
  localparam int MAT_DW = 16;
  localparam int MAT_W  = MAT_N * MAT_N * MAT_DW;

  typedef logic signed [MAT_DW-1:0] elem_t;
  typedef logic [MAT_W-1:0]         mat_flat_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } tx_state_t;

  // Bit offset of element [i][j]; element [0][0] sits in the MSBs.
  function automatic int elem_lsb(input int i, input int j,
                                  input int n = MAT_N, input int dw = MAT_DW);
    return (n * n - 1 - (n * i + j)) * dw;
  endfunction

endpackage

// File: rtl/mat_elem_sel.sv
// Combinational N*N:1 element mux keyed on (row, col) over a packed matrix.
module mat_elem_sel
  import mat_pkg::*;
#(
  parameter int DW = MAT_DW,
  parameter int N  = MAT_N,
  parameter int IW = $clog2(N)
) (
  input  logic [N*N*DW-1:0]    mat,
  input  logic [IW-1:0]        row,
  input  logic [IW-1:0]        col,
  output logic signed [DW-1:0] elem
);

  // Select the element whose coordinates match; bits pass through untouched.
  always_comb begin
    elem = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (row == IW'(i) && col == IW'(j)) begin
          elem = mat[elem_lsb(i, j, N, DW) +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/mat_stream_tx.sv
// Single-buffered matrix-to-element stream transmitter (row- or column-major).
module mat_stream_tx
  import mat_pkg::*;
#(
  parameter int DW = MAT_DW,
  parameter int N  = MAT_N,
  parameter int IW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*N*DW-1:0]    mat_in,
  input  logic                 mat_col_major,
  input  logic                 mat_valid,
  output logic                 mat_ready,
  output logic signed [DW-1:0] out_data,
  output logic [IW-1:0]        out_row,
  output logic [IW-1:0]        out_col,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  tx_state_t           state_q, state_d;
  logic [N*N*DW-1:0]   held_q;
  logic                order_q;
  logic [IW-1:0]       row_q, col_q;
  logic                row_end, col_end;
  logic                fire, capture;
  logic signed [DW-1:0] elem;

  assign row_end = (row_q == IW'(N - 1));
  assign col_end = (col_q == IW'(N - 1));

  // Next state and per-state outputs.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mat_valid) state_d = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = row_end && col_end;
        // Last beat leaving with no follow-up matrix drops back to IDLE.
        if (out_ready && row_end && col_end && !mat_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final beat frees the buffer in the same cycle for zero-bubble reload.
  assign fire      = out_valid && out_ready;
  assign mat_ready = (state_q == IDLE) || (fire && out_last);
  assign capture   = mat_valid && mat_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Held matrix, read order and element counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      order_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else if (capture) begin
      held_q  <= mat_in;
      order_q <= mat_col_major;
      row_q   <= '0;
      col_q   <= '0;
    end else if (fire) begin
      if (order_q) begin
        row_q <= row_end ? '0 : row_q + 1'b1;
        if (row_end) col_q <= col_end ? '0 : col_q + 1'b1;
      end else begin
        col_q <= col_end ? '0 : col_q + 1'b1;
        if (col_end) row_q <= row_end ? '0 : row_q + 1'b1;
      end
    end
  end

  mat_elem_sel #(
    .DW (DW),
    .N  (N),
    .IW (IW)
  ) u_sel (
    .mat  (held_q),
    .row  (row_q),
    .col  (col_q),
    .elem (elem)
  );

  assign out_data = elem;
  assign out_row  = row_q;
  assign out_col  = col_q;

endmodule

// File: tb/tb_mat_stream_tx.sv
// Self-checking bench for mat_stream_tx with a behavioural order model.
module tb_mat_stream_tx;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int NE = N * N;
  localparam int MW = NE * DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [MW-1:0]        mat_in;
  logic                 mat_col_major;
  logic                 mat_valid;
  logic                 mat_ready;
  logic signed [DW-1:0] out_data;
  logic [IW-1:0]        out_row;
  logic [IW-1:0]        out_col;
  logic                 out_last;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;

  int checks = 0;
  int passes = 0;

  // Beats collected by stream_one
  logic [DW-1:0] q_data[$];
  int            q_row[$];
  int            q_col[$];
  int            q_cyc[$];
  logic          q_last[$];
  int            acc_cyc;
  int            stall_viol;
  int            mr_viol;

  always #5 clk = ~clk;

  mat_stream_tx #(.DW(DW), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .mat_in        (mat_in),
    .mat_col_major (mat_col_major),
    .mat_valid     (mat_valid),
    .mat_ready     (mat_ready),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  // Reference: k-th beat of a matrix in the given order
  function automatic int exp_row(input logic cm, input int k);
    return cm ? (k % N) : (k / N);
  endfunction

  function automatic int exp_col(input logic cm, input int k);
    return cm ? (k / N) : (k % N);
  endfunction

  function automatic logic [DW-1:0] exp_elem(input logic [MW-1:0] m, input logic cm, input int k);
    int i, j;
    i = exp_row(cm, k);
    j = exp_col(cm, k);
    return m[(NE - 1 - (N * i + j)) * DW +: DW];
  endfunction

  function automatic logic [MW-1:0] pack_seq();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(NE - 1 - (N * i + j)) * DW +: DW] = DW'(4 * i + j + 1);
    return m;
  endfunction

  function automatic logic [MW-1:0] pack_alt();
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        m[(NE - 1 - (N * i + j)) * DW +: DW] = (((N * i + j) % 2) == 0) ? 16'hFFFF : 16'h8000;
    return m;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int k = 0; k < NE; k++) m[k * DW +: DW] = DW'($urandom);
    return m;
  endfunction

  // Offer one matrix, then collect its beats; optionally scramble inputs mid-stream
  task automatic stream_one(input logic [MW-1:0] m, input logic cm, input int ready_pct,
                            input int budget, input bit scramble);
    int cyc;
    bit accepted, prev_stall;
    logic [DW-1:0] pd;
    int pr, pc;
    logic pl;
    q_data.delete(); q_row.delete(); q_col.delete(); q_cyc.delete(); q_last.delete();
    stall_viol = 0; mr_viol = 0; acc_cyc = -1;
    accepted = 0; prev_stall = 0; cyc = 0;
    pd = '0; pr = 0; pc = 0; pl = 1'b0;
    while (q_data.size() < NE && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!accepted) begin
        mat_in = m; mat_col_major = cm; mat_valid = 1'b1;
      end else if (scramble) begin
        mat_in = rand_mat(); mat_col_major = 1'($urandom);
        mat_valid = (q_data.size() < NE - 1);
      end else begin
        mat_valid = 1'b0;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (prev_stall) begin
        if (!out_valid || out_data !== pd || out_row !== IW'(pr) || out_col !== IW'(pc) || out_last !== pl)
          stall_viol++;
      end
      if (accepted && out_valid) begin
        if (mat_ready !== (out_ready && out_last)) mr_viol++;
        if (out_ready) begin
          q_data.push_back(out_data); q_row.push_back(int'(out_row));
          q_col.push_back(int'(out_col)); q_last.push_back(out_last); q_cyc.push_back(cyc);
        end
        prev_stall = !out_ready;
        pd = out_data; pr = int'(out_row); pc = int'(out_col); pl = out_last;
      end else begin
        prev_stall = 0;
      end
      if (!accepted && mat_valid && mat_ready) begin
        accepted = 1; acc_cyc = cyc;
      end
    end
    mat_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mat_valid = 1'b1; mat_in = rand_mat(); mat_col_major = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; mat_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0 (mat_valid with rst captured)", busy); else passes++;
    checks++; if (mat_ready !== 1'b1) $display("FAIL reset_mat_ready: got %b expected 1", mat_ready); else passes++;
    checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else passes++;
    checks++; if (out_row !== '0 || out_col !== '0)
      $display("FAIL reset_row_col: got %0d,%0d expected 0,0", out_row, out_col); else passes++;
  endtask

  task automatic test_row_major();
    logic [MW-1:0] m;
    m = pack_seq();
    stream_one(m, 1'b0, 100, 40, 0);
    checks++; if (q_data.size() !== NE) $display("FAIL row_count: got %0d expected %0d", q_data.size(), NE); else passes++;
    for (int k = 0; k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== DW'(k + 1) || q_row[k] !== k / N || q_col[k] !== k % N || q_last[k] !== (k == NE - 1)
          || q_cyc[k] !== acc_cyc + 1 + k)
        $display("FAIL row_beat%0d: got d=%0h r=%0d c=%0d l=%b cyc=%0d expected d=%0h r=%0d c=%0d l=%b cyc=%0d",
                 k, q_data[k], q_row[k], q_col[k], q_last[k], q_cyc[k], k + 1, k / N, k % N, k == NE - 1, acc_cyc + 1 + k);
      else passes++;
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || mat_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL row_after: got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, mat_ready, busy); else passes++;
  endtask

  task automatic test_col_major();
    logic [MW-1:0] m;
    int ev;
    m = pack_seq();
    stream_one(m, 1'b1, 100, 40, 0);
    checks++; if (q_data.size() !== NE) $display("FAIL col_count: got %0d expected %0d", q_data.size(), NE); else passes++;
    for (int k = 0; k < q_data.size(); k++) begin
      ev = 4 * (k % N) + (k / N) + 1;
      checks++;
      if (q_data[k] !== DW'(ev) || q_row[k] !== k % N || q_col[k] !== k / N || q_last[k] !== (k == NE - 1)
          || q_cyc[k] !== acc_cyc + 1 + k)
        $display("FAIL col_beat%0d: got d=%0d r=%0d c=%0d l=%b expected d=%0d r=%0d c=%0d l=%b",
                 k, q_data[k], q_row[k], q_col[k], q_last[k], ev, k % N, k / N, k == NE - 1);
      else passes++;
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || mat_ready !== 1'b1)
      $display("FAIL col_after: got valid=%b ready=%b expected 0 1", out_valid, mat_ready); else passes++;
  endtask

  task automatic test_backpressure();
    logic [MW-1:0] m;
    logic cm;
    for (int r = 0; r < 3; r++) begin
      m  = (r == 0) ? pack_seq() : rand_mat();
      cm = (r == 0) ? 1'b0 : 1'($urandom);
      stream_one(m, cm, 50, 400, 0);
      checks++; if (q_data.size() !== NE) $display("FAIL bp%0d_count: got %0d expected %0d", r, q_data.size(), NE); else passes++;
      checks++; if (stall_viol !== 0) $display("FAIL bp%0d_stall_stable: got %0d changes expected 0", r, stall_viol); else passes++;
      checks++; if (mr_viol !== 0) $display("FAIL bp%0d_mat_ready: got %0d bad cycles expected 0", r, mr_viol); else passes++;
      for (int k = 0; k < q_data.size(); k++) begin
        checks++;
        if (q_data[k] !== exp_elem(m, cm, k) || q_row[k] !== exp_row(cm, k) || q_col[k] !== exp_col(cm, k)
            || q_last[k] !== (k == NE - 1))
          $display("FAIL bp%0d_beat%0d: got d=%0h r=%0d c=%0d l=%b expected d=%0h r=%0d c=%0d",
                   r, k, q_data[k], q_row[k], q_col[k], q_last[k], exp_elem(m, cm, k), exp_row(cm, k), exp_col(cm, k));
        else passes++;
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] a, b;
    logic cmb;
    logic [DW-1:0] ed;
    int k, er, ec;
    bit is_a;
    a = pack_seq(); b = pack_alt(); cmb = 1'($urandom);
    @(negedge clk);
    mat_in = a; mat_col_major = 1'b0; mat_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (mat_ready !== 1'b1) $display("FAIL b2b_accept_a: got %b expected 1", mat_ready); else passes++;
    for (int c = 1; c <= 2 * NE; c++) begin
      @(negedge clk);
      if (c == 1) begin mat_in = b; mat_col_major = cmb; end
      if (c == NE + 1) begin mat_valid = 1'b0; mat_in = rand_mat(); end
      #1;
      is_a = (c <= NE);
      k  = is_a ? c - 1 : c - 1 - NE;
      ed = is_a ? exp_elem(a, 1'b0, k) : exp_elem(b, cmb, k);
      er = is_a ? exp_row(1'b0, k) : exp_row(cmb, k);
      ec = is_a ? exp_col(1'b0, k) : exp_col(cmb, k);
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed || out_row !== IW'(er) || out_col !== IW'(ec)
          || out_last !== (k == NE - 1) || mat_ready !== (k == NE - 1))
        $display("FAIL b2b_cycle%0d: got v=%b d=%0h r=%0d c=%0d l=%b mr=%b expected v=1 d=%0h r=%0d c=%0d l=%b mr=%b",
                 c, out_valid, out_data, out_row, out_col, out_last, mat_ready, ed, er, ec, k == NE - 1, k == NE - 1);
      else passes++;
    end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_after: got valid=%b busy=%b expected 0 0", out_valid, busy); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] m, m2;
    logic cm, cm2;
    int lasts;
    m = rand_mat(); cm = 1'($urandom); lasts = 0;
    @(negedge clk);
    mat_in = m; mat_col_major = cm; mat_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mat_valid = 1'b0;
      #1;
      if (out_last) lasts++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (lasts !== 0) $display("FAIL rstmid_early_last: got %0d expected 0", lasts); else passes++;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || mat_ready !== 1'b1 || out_last !== 1'b0)
      $display("FAIL rstmid_state: got v=%b busy=%b mr=%b l=%b expected 0 0 1 0", out_valid, busy, mat_ready, out_last);
    else passes++;
    m2 = rand_mat(); cm2 = 1'($urandom);
    stream_one(m2, cm2, 100, 40, 0);
    checks++; if (q_data.size() !== NE) $display("FAIL rstmid_count: got %0d expected %0d", q_data.size(), NE); else passes++;
    for (int k = 0; k < q_data.size(); k++) begin
      checks++;
      if (q_data[k] !== exp_elem(m2, cm2, k) || q_row[k] !== exp_row(cm2, k) || q_col[k] !== exp_col(cm2, k)
          || q_last[k] !== (k == NE - 1))
        $display("FAIL rstmid_beat%0d: got d=%0h r=%0d c=%0d expected d=%0h r=%0d c=%0d",
                 k, q_data[k], q_row[k], q_col[k], exp_elem(m2, cm2, k), exp_row(cm2, k), exp_col(cm2, k));
      else passes++;
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_inputs();
    logic [MW-1:0] m;
    logic cm;
    for (int r = 0; r < 2; r++) begin
      m = rand_mat(); cm = 1'(r);
      stream_one(m, cm, (r == 0) ? 100 : 60, 400, 1);
      checks++; if (q_data.size() !== NE) $display("FAIL ign%0d_count: got %0d expected %0d", r, q_data.size(), NE); else passes++;
      checks++; if (mr_viol !== 0) $display("FAIL ign%0d_mat_ready: got %0d bad cycles expected 0", r, mr_viol); else passes++;
      for (int k = 0; k < q_data.size(); k++) begin
        checks++;
        if (q_data[k] !== exp_elem(m, cm, k) || q_row[k] !== exp_row(cm, k) || q_col[k] !== exp_col(cm, k))
          $display("FAIL ign%0d_beat%0d: got d=%0h r=%0d c=%0d expected d=%0h r=%0d c=%0d",
                   r, k, q_data[k], q_row[k], q_col[k], exp_elem(m, cm, k), exp_row(cm, k), exp_col(cm, k));
        else passes++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL ign%0d_after: got valid=%b expected 0", r, out_valid); else passes++;
    end
  endtask

  initial begin
    rst = 1'b1; mat_in = '0; mat_col_major = 1'b0; mat_valid = 1'b0; out_ready = 1'b0;
    test_reset();
    test_row_major();
    test_col_major();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_ignored_inputs();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
